// File: rtl/deserializer_fifo.sv
// Serial-to-parallel word assembler feeding a DEPTH-entry show-ahead FIFO.
// Bits are accepted only while the FIFO has room; words pop on ack_in.
module deserializer_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                           clk_100mhz,
  input  logic                           reset_n,
  input  logic                           data_in,
  input  logic                           write_in,
  input  logic                           ack_in,
  input  logic                           clear_in,
  output logic [WIDTH-1:0]               data_out,
  output logic                           data_ready,
  output logic                           status_out,
  output logic [$clog2(DEPTH+1)-1:0]     fifo_count,
  output logic                           overflow_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int BW = $clog2(WIDTH);

  // Partial word never holds more than WIDTH-1 bits; the last bit goes straight into the word.
  logic [WIDTH-2:0] shift_reg, shift_next;
  logic [BW-1:0]    bit_cnt_reg, bit_cnt_next;
  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             overflow_reg, overflow_next;
  logic [WIDTH-1:0] word_next;
  logic [WIDTH-2:0] shift_adv;
  logic             accept, push, pop;
  logic [WIDTH-1:0] mem [DEPTH];

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign word_next = {shift_reg, data_in};
      assign shift_adv = word_next[WIDTH-2:0];
    end else begin : g_lsb
      assign word_next = {data_in, shift_reg};
      assign shift_adv = word_next[WIDTH-1:1];
    end
  endgenerate

  always_comb begin
    status_out    = (count_reg != CW'(DEPTH));
    data_ready    = (count_reg != '0);
    accept        = write_in & status_out & ~clear_in;
    push          = accept & (bit_cnt_reg == BW'(WIDTH-1));
    pop           = ack_in & data_ready & ~clear_in;
    shift_next    = shift_reg;
    bit_cnt_next  = bit_cnt_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    if (clear_in) begin
      shift_next    = '0;
      bit_cnt_next  = '0;
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      count_next    = '0;
      overflow_next = 1'b0;
    end else begin
      if (accept) begin
        shift_next   = shift_adv;
        bit_cnt_next = push ? '0 : bit_cnt_reg + BW'(1);
      end
      if (write_in && !status_out)
        overflow_next = 1'b1;
      if (push)
        wr_ptr_next = wr_ptr_reg + PW'(1);
      if (pop)
        rd_ptr_next = rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      shift_reg    <= shift_next;
      bit_cnt_reg  <= bit_cnt_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  // Storage needs no reset: stale entries are masked by data_ready.
  always_ff @(posedge clk_100mhz) begin
    if (push)
      mem[wr_ptr_reg] <= word_next;
  end

  assign data_out     = data_ready ? mem[rd_ptr_reg] : '0;
  assign fifo_count   = count_reg;
  assign overflow_out = overflow_reg;

endmodule

// File: tb/tb_deserializer_fifo.sv
// Checks two deserializer_fifo instances (MSB-first and LSB-first) on shared stimulus
// against a queue-based reference model, a vector table and directed corner sequences.
module tb_deserializer_fifo;

  localparam int W = 8;
  localparam int D = 4;

  logic clk_100mhz = 1'b0;
  logic reset_n, data_in, write_in, ack_in, clear_in;
  logic [W-1:0] out_m, out_l;
  logic         rdy_m, rdy_l, st_m, st_l, ovf_m, ovf_l;
  logic [2:0]   cnt_m, cnt_l;

  int checks = 0;
  int failures = 0;

  always #5 clk_100mhz = ~clk_100mhz;

  deserializer_fifo #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1)) dut_msb (
    .clk_100mhz(clk_100mhz), .reset_n(reset_n), .data_in(data_in), .write_in(write_in),
    .ack_in(ack_in), .clear_in(clear_in), .data_out(out_m), .data_ready(rdy_m),
    .status_out(st_m), .fifo_count(cnt_m), .overflow_out(ovf_m));

  deserializer_fifo #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(0)) dut_lsb (
    .clk_100mhz(clk_100mhz), .reset_n(reset_n), .data_in(data_in), .write_in(write_in),
    .ack_in(ack_in), .clear_in(clear_in), .data_out(out_l), .data_ready(rdy_l),
    .status_out(st_l), .fifo_count(cnt_l), .overflow_out(ovf_l));

  // Reference model: list of pending bits plus one word queue per bit order.
  bit           partial[$];
  logic [W-1:0] q_m[$];
  logic [W-1:0] q_l[$];
  bit           m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    partial.delete();
    q_m.delete();
    q_l.delete();
    m_ovf = 0;
  endtask

  task automatic model_update(input bit w, input bit d, input bit a, input bit c);
    logic [W-1:0] wm, wl;
    bit full, empty;
    if (c) begin
      model_reset();
      return;
    end
    full  = (q_m.size() == D);
    empty = (q_m.size() == 0);
    if (a && !empty) begin
      void'(q_m.pop_front());
      void'(q_l.pop_front());
    end
    if (w && full) m_ovf = 1;
    if (w && !full) begin
      partial.push_back(d);
      if (partial.size() == W) begin
        wm = '0;
        wl = '0;
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = partial[i];
          wl[i]     = partial[i];
        end
        q_m.push_back(wm);
        q_l.push_back(wl);
        partial.delete();
      end
    end
  endtask

  task automatic model_check();
    int n;
    n = q_m.size();
    chk("cnt_m",  {29'b0, cnt_m}, n);
    chk("cnt_l",  {29'b0, cnt_l}, n);
    chk("rdy_m",  {31'b0, rdy_m}, (n != 0));
    chk("rdy_l",  {31'b0, rdy_l}, (n != 0));
    chk("st_m",   {31'b0, st_m},  (n != D));
    chk("st_l",   {31'b0, st_l},  (n != D));
    chk("ovf_m",  {31'b0, ovf_m}, m_ovf);
    chk("ovf_l",  {31'b0, ovf_l}, m_ovf);
    chk("out_m",  {24'b0, out_m}, (n != 0) ? {24'b0, q_m[0]} : 32'h0);
    chk("out_l",  {24'b0, out_l}, (n != 0) ? {24'b0, q_l[0]} : 32'h0);
  endtask

  task automatic step(input bit w, input bit d, input bit a, input bit c);
    write_in = w; data_in = d; ack_in = a; clear_in = c;
    @(posedge clk_100mhz);
    model_update(w, d, a, c);
    #1;
    write_in = 0; data_in = 0; ack_in = 0; clear_in = 0;
    model_check();
  endtask

  task automatic send_word(input logic [W-1:0] v, input bit a);
    for (int b = W - 1; b >= 0; b--) step(1'b1, v[b], a, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"}, {31'b0, rdy_m}, 0);
    chk({tag, "_out"}, {24'b0, out_m}, 0);
    chk({tag, "_cnt"}, {29'b0, cnt_m}, 0);
    chk({tag, "_st"},  {31'b0, st_m},  1);
    chk({tag, "_ovf"}, {31'b0, ovf_m}, 0);
    chk({tag, "_outl"}, {24'b0, out_l}, 0);
  endtask

  typedef struct {
    bit w, d, a, c;
    bit rdy;
    logic [W-1:0] om, ol;
    logic [2:0] cnt;
    bit st, ov;
  } vec_t;

  vec_t tbl[9];

  initial begin
    reset_n = 0; data_in = 0; write_in = 0; ack_in = 0; clear_in = 0;
    model_reset();
    #3;
    chk_reset_vals("por");
    @(negedge clk_100mhz);
    @(negedge clk_100mhz);
    reset_n = 1;

    // Alternating stream 0,1,0,1,... then a single ack.
    for (int i = 0; i < 8; i++) begin
      tbl[i].w = 1; tbl[i].d = (i % 2 == 1); tbl[i].a = 0; tbl[i].c = 0;
      tbl[i].rdy = (i == 7); tbl[i].om = (i == 7) ? 8'h55 : 8'h00;
      tbl[i].ol = (i == 7) ? 8'hAA : 8'h00; tbl[i].cnt = (i == 7) ? 3'd1 : 3'd0;
      tbl[i].st = 1; tbl[i].ov = 0;
    end
    tbl[8].w = 0; tbl[8].d = 0; tbl[8].a = 1; tbl[8].c = 0;
    tbl[8].rdy = 0; tbl[8].om = 8'h00; tbl[8].ol = 8'h00; tbl[8].cnt = 3'd0;
    tbl[8].st = 1; tbl[8].ov = 0;
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].w, tbl[i].d, tbl[i].a, tbl[i].c);
      chk($sformatf("tbl%0d_rdy", i), {31'b0, rdy_m}, tbl[i].rdy);
      chk($sformatf("tbl%0d_om", i),  {24'b0, out_m}, {24'b0, tbl[i].om});
      chk($sformatf("tbl%0d_ol", i),  {24'b0, out_l}, {24'b0, tbl[i].ol});
      chk($sformatf("tbl%0d_cnt", i), {29'b0, cnt_m}, {29'b0, tbl[i].cnt});
      chk($sformatf("tbl%0d_st", i),  {31'b0, st_m},  tbl[i].st);
      chk($sformatf("tbl%0d_ov", i),  {31'b0, ovf_m}, tbl[i].ov);
    end

    // Fill to full, overflow, then drain in order.
    send_word(8'h11, 0); send_word(8'h22, 0); send_word(8'h33, 0); send_word(8'h44, 0);
    chk("full_cnt", {29'b0, cnt_m}, 4);
    chk("full_st",  {31'b0, st_m}, 0);
    step(1, 1, 0, 0);
    chk("ovf_set", {31'b0, ovf_m}, 1);
    chk("ovf_cnt", {29'b0, cnt_m}, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d", k), {24'b0, out_m}, 32'h11 * (k + 1));
      step(0, 0, 1, 0);
    end
    chk("drained_rdy", {31'b0, rdy_m}, 0);

    // Continuous ack while streaming: each word seen once, count stays <= 1.
    for (int k = 0; k < 5; k++) begin
      logic [W-1:0] v;
      v = (k % 2 == 0) ? 8'hA5 : 8'h5A;
      for (int b = W - 1; b >= 0; b--) begin
        step(1'b1, v[b], 1'b1, 1'b0);
        chk("ack_cnt_le1", {31'b0, (cnt_m > 3'd1)}, 0);
      end
      chk($sformatf("ack_word%0d", k), {24'b0, out_m}, {24'b0, v});
    end
    step(0, 0, 1, 0);
    chk("ack_empty", {31'b0, rdy_m}, 0);
    chk("ovf_sticky", {31'b0, ovf_m}, 1);

    // Clear with write and ack in the same cycle.
    send_word(8'h12, 0); send_word(8'h34, 0);
    step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
    step(1, 1, 1, 1);
    chk("clr_cnt", {29'b0, cnt_m}, 0);
    chk("clr_rdy", {31'b0, rdy_m}, 0);
    chk("clr_ovf", {31'b0, ovf_m}, 0);
    send_word(8'hC3, 0);
    chk("clr_word", {24'b0, out_m}, 32'hC3);
    chk("clr_wcnt", {29'b0, cnt_m}, 1);

    // Asynchronous reset mid-word with a stored word.
    send_word(8'h77, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
    #2 reset_n = 0;
    #1;
    model_reset();
    chk_reset_vals("arst");
    @(negedge clk_100mhz);
    reset_n = 1;
    send_word(8'hF0, 0);
    chk("arst_word", {24'b0, out_m}, 32'hF0);
    chk("arst_cnt",  {29'b0, cnt_m}, 1);
    step(0, 0, 1, 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++)
      step(($urandom % 4) != 0, $urandom % 2, ($urandom % 3) == 0, ($urandom % 97) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/deserializer_fifo.md
Name: deserializer_fifo

Overview:
- Parametrised successor to the single-byte serial-to-parallel deserializer.
- Assembles serial bits into words of WIDTH bits, with a selectable bit order.
- Completed words go into a DEPTH-entry FIFO, so the serial producer keeps streaming while the consumer drains words with ack_in.
- Sits between the serial link front-end and the word-level consumer in the 100 MHz domain.

Parameters:
- WIDTH, 8: word width in bits (>=2).
- DEPTH, 4: number of FIFO entries (power of 2, >=2).
- MSB_FIRST, 1: 1 = first received bit lands in data_out[WIDTH-1]; 0 = first bit lands in data_out[0].

Ports:
- clk_100mhz, input, 1: system clock; all logic on rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- data_in, input, 1: serial data bit.
- write_in, input, 1: data_in valid this cycle.
- ack_in, input, 1: consumer pops the head word.
- clear_in, input, 1: synchronous flush of the partial word, the FIFO and overflow_out.
- data_out, output, WIDTH: head-of-FIFO word (show-ahead).
- data_ready, output, 1: FIFO not empty.
- status_out, output, 1: block can accept bits (FIFO not full).
- fifo_count, output, $clog2(DEPTH+1): number of stored words.
- overflow_out, output, 1: sticky flag; a bit was offered while status_out=0.

Behaviour:
- Reset (reset_n=0, asynchronous), all cleared:
  - bit counter, shift register, FIFO pointers, fifo_count = 0
  - data_out = 0, data_ready = 0, status_out = 1, overflow_out = 0
- Bit acceptance: a bit is accepted on a rising edge where write_in=1 and status_out=1.
  - MSB_FIRST=1: shift left, new bit enters at LSB.
  - MSB_FIRST=0: shift right, new bit enters at MSB.
  - Bit counter increments from 0 to WIDTH-1.
- Word completion: on the edge accepting the WIDTH-th bit:
  - The assembled word, including that bit, is written to FIFO[wr_ptr].
  - wr_ptr and fifo_count are updated; the bit counter returns to 0.
  - data_ready rises after that same edge (0 cycles after the last bit).
  - Consecutive words need no idle cycle.
- Outputs:
  - status_out = (fifo_count != DEPTH), registered-derived with no dependency on ack_in.
  - When the FIFO is full, further bits are dropped, the partial word is frozen and overflow_out is set.
  - The partial word resumes when space frees.
- Pop: ack_in=1 with data_ready=1 advances rd_ptr on the edge.
  - ack_in while empty is ignored: no pointer change, no flag.
- Simultaneous push and pop (word completion plus ack_in, FIFO neither empty nor full): both happen and fifo_count is unchanged.
  - When empty, the pushed word becomes visible the next cycle.
  - When full, the push is blocked by status_out=0 while the pop proceeds.
- Data output:
  - data_out = FIFO[rd_ptr] when data_ready=1, else 0.
  - Stable until ack_in pops it.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH; full/empty are decided by fifo_count.
- clear_in=1: on the next edge, counter, pointers, fifo_count and overflow_out go to 0.
  - Any write_in or ack_in in the same cycle is discarded.
  - clear_in has priority over everything except reset_n.
- Reset mid-word or with a non-empty FIFO: everything is discarded immediately (asynchronous); no partial word survives.
- overflow_out is cleared only by reset_n or clear_in.

Test Plan:
- WIDTH=8, MSB_FIRST=1: send bits 0,1,0,1,0,1,0,1 on consecutive cycles -> data_ready=1 and data_out=0x55 after the 8th edge, fifo_count=1. ack_in for one cycle -> data_ready=0, data_out=0, status_out=1.
- MSB_FIRST=0, same stream -> data_out=0xAA.
- Stream 4 words 0x11,0x22,0x33,0x44 back-to-back without ack -> fifo_count=4, status_out=0. A further write_in=1 -> overflow_out=1, fifo_count stays 4. Four acks -> words pop in order 0x11..0x44, then data_ready=0.
- Hold ack_in=1 continuously while streaming 0xA5,0x5A -> each word is visible exactly once, fifo_count never exceeds 1. After 5 words the pointers have wrapped and the order is preserved.
- Send 4 bits of 1, then pulse reset_n=0 between edges -> all outputs are at reset values immediately. Next 8 bits 0xF0 (MSB_FIRST=1) yield exactly 0xF0, with no leftover bits.
- With 2 words stored and 3 partial bits: assert clear_in together with write_in and ack_in -> next cycle fifo_count=0, data_ready=0, overflow_out=0, and the next 8 bits form a clean word.
